// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares NUM_CHANNELS memory channels among NUM_CONSUMERS requesters
//            using per-channel handshake FSMs and a round-robin allocator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [ADDR_BITS-1:0]     consumer_read_address  [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [DATA_BITS-1:0]     consumer_read_data     [NUM_CONSUMERS],
    input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
    input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
    input  logic [DATA_BITS-1:0]     consumer_write_data    [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_write_ready,

    output logic [NUM_CHANNELS-1:0]  mem_read_valid,
    output logic [ADDR_BITS-1:0]     mem_read_address  [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]  mem_read_ready,
    input  logic [DATA_BITS-1:0]     mem_read_data     [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0]  mem_write_valid,
    output logic [ADDR_BITS-1:0]     mem_write_address [NUM_CHANNELS],
    output logic [DATA_BITS-1:0]     mem_write_data    [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]  mem_write_ready
);

    localparam int         c_IDX_W   = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic       c_WR_EN   = (WRITE_ENABLE != 0);

    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_READ_WAIT  = 3'd1;
    localparam logic [2:0] c_ST_WRITE_WAIT = 3'd2;
    localparam logic [2:0] c_ST_READ_RELAY = 3'd3;
    localparam logic [2:0] c_ST_WRITE_RELAY= 3'd4;

    logic [2:0]               state_q  [NUM_CHANNELS];
    logic [2:0]               state_d  [NUM_CHANNELS];
    logic [c_IDX_W-1:0]       owner_q  [NUM_CHANNELS];
    logic [c_IDX_W-1:0]       owner_d  [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] claimed_q, claimed_d;
    logic [c_IDX_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic [NUM_CHANNELS-1:0]  mem_read_valid_q, mem_read_valid_d;
    logic [NUM_CHANNELS-1:0]  mem_write_valid_q, mem_write_valid_d;
    logic [ADDR_BITS-1:0]     mem_read_address_q  [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]     mem_read_address_d  [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]     mem_write_address_q [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]     mem_write_address_d [NUM_CHANNELS];
    logic [DATA_BITS-1:0]     mem_write_data_q    [NUM_CHANNELS];
    logic [DATA_BITS-1:0]     mem_write_data_d    [NUM_CHANNELS];

    logic [NUM_CONSUMERS-1:0] consumer_read_ready_q, consumer_read_ready_d;
    logic [NUM_CONSUMERS-1:0] consumer_write_ready_q, consumer_write_ready_d;
    logic [DATA_BITS-1:0]     consumer_read_data_q [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]     consumer_read_data_d [NUM_CONSUMERS];

    // Scratch for the allocator: consumers unavailable this cycle, and those finishing.
    logic [NUM_CONSUMERS-1:0] w_taken;
    logic [NUM_CONSUMERS-1:0] w_released;
    logic                     w_found;
    int                       w_sel;
    int                       w_cand;

    always_comb begin
        state_d                = state_q;
        owner_d                = owner_q;
        rr_ptr_d               = rr_ptr_q;
        mem_read_valid_d       = mem_read_valid_q;
        mem_write_valid_d      = mem_write_valid_q;
        mem_read_address_d     = mem_read_address_q;
        mem_write_address_d    = mem_write_address_q;
        mem_write_data_d       = mem_write_data_q;
        consumer_read_ready_d  = consumer_read_ready_q;
        consumer_write_ready_d = consumer_write_ready_q;
        consumer_read_data_d   = consumer_read_data_q;
        w_taken                = claimed_q;
        w_released             = '0;
        w_found                = 1'b0;
        w_sel                  = 0;
        w_cand                 = 0;

        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            w_found = 1'b0;
            w_sel   = 0;
            case (state_q[ch])
                c_ST_IDLE: begin
                    for (int k = 0; k < NUM_CONSUMERS; k++) begin
                        w_cand = (int'(rr_ptr_q) + k) % NUM_CONSUMERS;
                        if (!w_found && !w_taken[w_cand] &&
                            (consumer_read_valid[w_cand] ||
                             (c_WR_EN && consumer_write_valid[w_cand]))) begin
                            w_found = 1'b1;
                            w_sel   = w_cand;
                        end
                    end
                    if (w_found) begin
                        w_taken[w_sel] = 1'b1;
                        owner_d[ch]    = c_IDX_W'(w_sel);
                        rr_ptr_d       = c_IDX_W'((w_sel + 1) % NUM_CONSUMERS);
                        // Reads take priority when a consumer raises both valids.
                        if (consumer_read_valid[w_sel]) begin
                            state_d[ch]            = c_ST_READ_WAIT;
                            mem_read_valid_d[ch]   = 1'b1;
                            mem_read_address_d[ch] = consumer_read_address[w_sel];
                        end else begin
                            state_d[ch]             = c_ST_WRITE_WAIT;
                            mem_write_valid_d[ch]   = 1'b1;
                            mem_write_address_d[ch] = consumer_write_address[w_sel];
                            mem_write_data_d[ch]    = consumer_write_data[w_sel];
                        end
                    end
                end
                c_ST_READ_WAIT: begin
                    if (mem_read_ready[ch]) begin
                        mem_read_valid_d[ch]                  = 1'b0;
                        consumer_read_data_d[owner_q[ch]]     = mem_read_data[ch];
                        consumer_read_ready_d[owner_q[ch]]    = 1'b1;
                        state_d[ch]                           = c_ST_READ_RELAY;
                    end
                end
                c_ST_WRITE_WAIT: begin
                    if (mem_write_ready[ch]) begin
                        mem_write_valid_d[ch]                 = 1'b0;
                        consumer_write_ready_d[owner_q[ch]]   = 1'b1;
                        state_d[ch]                           = c_ST_WRITE_RELAY;
                    end
                end
                c_ST_READ_RELAY: begin
                    if (!consumer_read_valid[owner_q[ch]]) begin
                        consumer_read_ready_d[owner_q[ch]] = 1'b0;
                        w_released[owner_q[ch]]            = 1'b1;
                        state_d[ch]                        = c_ST_IDLE;
                    end
                end
                c_ST_WRITE_RELAY: begin
                    if (!consumer_write_valid[owner_q[ch]]) begin
                        consumer_write_ready_d[owner_q[ch]] = 1'b0;
                        w_released[owner_q[ch]]             = 1'b1;
                        state_d[ch]                         = c_ST_IDLE;
                    end
                end
                default: begin
                    state_d[ch] = c_ST_IDLE;
                end
            endcase
        end

        claimed_d = w_taken & ~w_released;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch]             <= c_ST_IDLE;
                owner_q[ch]             <= '0;
                mem_read_address_q[ch]  <= '0;
                mem_write_address_q[ch] <= '0;
                mem_write_data_q[ch]    <= '0;
            end
            for (int u = 0; u < NUM_CONSUMERS; u++) begin
                consumer_read_data_q[u] <= '0;
            end
            claimed_q              <= '0;
            rr_ptr_q               <= '0;
            mem_read_valid_q       <= '0;
            mem_write_valid_q      <= '0;
            consumer_read_ready_q  <= '0;
            consumer_write_ready_q <= '0;
        end else begin
            state_q                <= state_d;
            owner_q                <= owner_d;
            claimed_q              <= claimed_d;
            rr_ptr_q               <= rr_ptr_d;
            mem_read_valid_q       <= mem_read_valid_d;
            mem_write_valid_q      <= mem_write_valid_d;
            mem_read_address_q     <= mem_read_address_d;
            mem_write_address_q    <= mem_write_address_d;
            mem_write_data_q       <= mem_write_data_d;
            consumer_read_ready_q  <= consumer_read_ready_d;
            consumer_write_ready_q <= consumer_write_ready_d;
            consumer_read_data_q   <= consumer_read_data_d;
        end
    end

    assign mem_read_valid       = mem_read_valid_q;
    assign mem_read_address     = mem_read_address_q;
    assign mem_write_valid      = mem_write_valid_q;
    assign mem_write_address    = mem_write_address_q;
    assign mem_write_data       = mem_write_data_q;
    assign consumer_read_ready  = consumer_read_ready_q;
    assign consumer_read_data   = consumer_read_data_q;
    assign consumer_write_ready = consumer_write_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed and randomized self-checking bench for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int NC  = 4;
    localparam int NCH = 2;
    localparam int AW  = 8;
    localparam int DW  = 16;

    logic          clk;
    logic          reset;
    logic [NC-1:0] crv, cwv, crr, cwr;
    logic [AW-1:0] craddr [NC];
    logic [AW-1:0] cwaddr [NC];
    logic [DW-1:0] cwdata [NC];
    logic [DW-1:0] crdata [NC];
    logic [NCH-1:0] mrv, mrr, mwv, mwr;
    logic [AW-1:0] mraddr [NCH];
    logic [AW-1:0] mwaddr [NCH];
    logic [DW-1:0] mrdata [NCH];
    logic [DW-1:0] mwdata [NCH];

    int n_checks;
    int n_errors;

    // Reference model: per-consumer phase (0 free, 1 waiting on memory, 2 relaying).
    int            ph     [NC];
    logic          mk_rd  [NC];
    logic [AW-1:0] m_addr [NC];
    logic [DW-1:0] m_wd   [NC];
    logic [DW-1:0] m_rd   [NC];
    int            chan_u [NCH];
    int            rr;
    logic [DW-1:0] tbmem  [256];
    logic [DW-1:0] shadow [256];
    logic [NC-1:0] p_crr, p_cwr;

    mem_arbiter #(
        .ADDR_BITS    (AW),
        .DATA_BITS    (DW),
        .NUM_CONSUMERS(NC),
        .NUM_CHANNELS (NCH),
        .WRITE_ENABLE (1)
    ) u_dut (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (crv),
        .consumer_read_address (craddr),
        .consumer_read_ready   (crr),
        .consumer_read_data    (crdata),
        .consumer_write_valid  (cwv),
        .consumer_write_address(cwaddr),
        .consumer_write_data   (cwdata),
        .consumer_write_ready  (cwr),
        .mem_read_valid        (mrv),
        .mem_read_address      (mraddr),
        .mem_read_ready        (mrr),
        .mem_read_data         (mrdata),
        .mem_write_valid       (mwv),
        .mem_write_address     (mwaddr),
        .mem_write_data        (mwdata),
        .mem_write_ready       (mwr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        crv = '0;
        cwv = '0;
        mrr = '0;
        mwr = '0;
        for (int u = 0; u < NC; u++) begin
            craddr[u] = '0;
            cwaddr[u] = '0;
            cwdata[u] = '0;
        end
        for (int ch = 0; ch < NCH; ch++) mrdata[ch] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mrv"}, 32'(mrv), 32'(0));
        chk({tag, "_mwv"}, 32'(mwv), 32'(0));
        chk({tag, "_crr"}, 32'(crr), 32'(0));
        chk({tag, "_cwr"}, 32'(cwr), 32'(0));
        for (int ch = 0; ch < NCH; ch++) begin
            chk({tag, "_mraddr"}, 32'(mraddr[ch]), 32'(0));
            chk({tag, "_mwaddr"}, 32'(mwaddr[ch]), 32'(0));
            chk({tag, "_mwdata"}, 32'(mwdata[ch]), 32'(0));
        end
        for (int u = 0; u < NC; u++) chk({tag, "_crdata"}, 32'(crdata[u]), 32'(0));
    endtask

    // Compare DUT outputs with the model state reached at the last clock edge.
    task automatic compare_outputs();
        int  u;
        logic ev_r, ev_w, er, ew;
        for (int ch = 0; ch < NCH; ch++) begin
            u    = chan_u[ch];
            ev_r = (u >= 0) && (ph[u] == 1) && mk_rd[u];
            ev_w = (u >= 0) && (ph[u] == 1) && !mk_rd[u];
            chk($sformatf("mrv%0d", ch), 32'(mrv[ch]), 32'(ev_r));
            chk($sformatf("mwv%0d", ch), 32'(mwv[ch]), 32'(ev_w));
            if (ev_r) chk($sformatf("mraddr%0d", ch), 32'(mraddr[ch]), 32'(m_addr[u]));
            if (ev_w) begin
                chk($sformatf("mwaddr%0d", ch), 32'(mwaddr[ch]), 32'(m_addr[u]));
                chk($sformatf("mwdata%0d", ch), 32'(mwdata[ch]), 32'(m_wd[u]));
            end
        end
        for (int c = 0; c < NC; c++) begin
            er = (ph[c] == 2) && mk_rd[c];
            ew = (ph[c] == 2) && !mk_rd[c];
            chk($sformatf("crr%0d", c), 32'(crr[c]), 32'(er));
            chk($sformatf("cwr%0d", c), 32'(cwr[c]), 32'(ew));
            if (er) chk($sformatf("crdata%0d", c), 32'(crdata[c]), 32'(m_rd[c]));
            if (crr[c] && !p_crr[c])
                chk($sformatf("rd_sb%0d", c), 32'(crdata[c]), 32'(shadow[craddr[c]]));
            if (cwr[c] && !p_cwr[c]) shadow[cwaddr[c]] = cwdata[c];
        end
        p_crr = crr;
        p_cwr = cwr;
    endtask

    task automatic mem_respond();
        for (int ch = 0; ch < NCH; ch++) begin
            mrr[ch]    = mrv[ch] && ($urandom_range(0, 9) < 4);
            mrdata[ch] = mrr[ch] ? tbmem[mraddr[ch]] : DW'($urandom);
            mwr[ch]    = mwv[ch] && ($urandom_range(0, 9) < 4);
            if (mwr[ch]) tbmem[mwaddr[ch]] = mwdata[ch];
        end
    endtask

    task automatic drive_consumers();
        int  kind;
        logic acted;
        for (int u = 0; u < NC; u++) begin
            acted = 1'b0;
            if (crv[u] && crr[u] && $urandom_range(0, 1) == 0) begin
                crv[u] = 1'b0;
                acted  = 1'b1;
            end
            if (cwv[u] && cwr[u] && $urandom_range(0, 1) == 0) begin
                cwv[u] = 1'b0;
                acted  = 1'b1;
            end
            if ((crv[u] || cwv[u]) && ph[u] == 0 && $urandom_range(0, 19) == 0) begin
                crv[u] = 1'b0;
                cwv[u] = 1'b0;
                acted  = 1'b1;
            end else if ((crv[u] || cwv[u]) && ph[u] == 1 && $urandom_range(0, 29) == 0) begin
                crv[u] = 1'b0;
                cwv[u] = 1'b0;
                acted  = 1'b1;
            end
            if (!acted && !crv[u] && !cwv[u] && ph[u] == 0 && $urandom_range(0, 3) == 0) begin
                kind      = $urandom_range(0, 2);
                craddr[u] = {2'(u), 6'($urandom)};
                cwaddr[u] = {2'(u), 6'($urandom)};
                cwdata[u] = DW'($urandom);
                crv[u]    = (kind != 1);
                cwv[u]    = (kind != 0);
            end
        end
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_step();
        int fch[$];
        int elg[$];
        int u;
        int n;
        for (int ch = 0; ch < NCH; ch++) if (chan_u[ch] < 0) fch.push_back(ch);
        for (int k = 0; k < NC; k++) begin
            u = (rr + k) % NC;
            if (ph[u] == 0 && (crv[u] || cwv[u])) elg.push_back(u);
        end
        for (int ch = 0; ch < NCH; ch++) begin
            u = chan_u[ch];
            if (u >= 0) begin
                if (ph[u] == 1) begin
                    if (mk_rd[u] && mrr[ch]) begin
                        m_rd[u] = mrdata[ch];
                        ph[u]   = 2;
                    end else if (!mk_rd[u] && mwr[ch]) begin
                        ph[u] = 2;
                    end
                end else if (ph[u] == 2) begin
                    if (!(mk_rd[u] ? crv[u] : cwv[u])) begin
                        ph[u]      = 0;
                        chan_u[ch] = -1;
                    end
                end
            end
        end
        n = (fch.size() < elg.size()) ? fch.size() : elg.size();
        for (int i = 0; i < n; i++) begin
            u              = elg[i];
            chan_u[fch[i]] = u;
            ph[u]          = 1;
            mk_rd[u]       = crv[u];
            m_addr[u]      = crv[u] ? craddr[u] : cwaddr[u];
            m_wd[u]        = cwdata[u];
            rr             = (u + 1) % NC;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        clear_inputs();

        // Single read: request, memory ready on the third cycle, hold, then release.
        do_reset();
        chk_all_zero("rst");
        crv[2] = 1'b1; craddr[2] = 8'h10;
        cyc();
        chk("rd1_mrv", 32'(mrv), 32'(2'b01));
        chk("rd1_maddr", 32'(mraddr[0]), 32'h10);
        cyc();
        chk("rd1_hold", 32'(mrv), 32'(2'b01));
        chk("rd1_noready", 32'(crr), 32'(0));
        cyc();
        chk("rd1_hold2", 32'(mrv), 32'(2'b01));
        mrr[0] = 1'b1; mrdata[0] = 16'hBEEF;
        cyc();
        mrr[0] = 1'b0; mrdata[0] = 16'h0;
        chk("rd1_mrv_low", 32'(mrv), 32'(0));
        chk("rd1_crr", 32'(crr), 32'(4'b0100));
        chk("rd1_data", 32'(crdata[2]), 32'hBEEF);
        cyc();
        chk("rd1_crr_held", 32'(crr), 32'(4'b0100));
        crv[2] = 1'b0;
        cyc();
        chk("rd1_crr_drop", 32'(crr), 32'(0));

        // Two channels: consumers 1 and 3 served concurrently.
        do_reset();
        crv[1] = 1'b1; craddr[1] = 8'h41;
        crv[3] = 1'b1; craddr[3] = 8'hC2;
        cyc();
        chk("two_mrv", 32'(mrv), 32'(2'b11));
        chk("two_a0", 32'(mraddr[0]), 32'h41);
        chk("two_a1", 32'(mraddr[1]), 32'hC2);
        mrr = 2'b11; mrdata[0] = 16'h1111; mrdata[1] = 16'h3333;
        cyc();
        mrr = '0;
        chk("two_crr", 32'(crr), 32'(4'b1010));
        chk("two_d1", 32'(crdata[1]), 32'h1111);
        chk("two_d3", 32'(crdata[3]), 32'h3333);
        crv = '0;
        cyc();
        chk("two_crr_drop", 32'(crr), 32'(0));

        // Single write.
        do_reset();
        cwv[0] = 1'b1; cwaddr[0] = 8'h05; cwdata[0] = 16'h1234;
        cyc();
        chk("wr_mwv", 32'(mwv), 32'(2'b01));
        chk("wr_addr", 32'(mwaddr[0]), 32'h05);
        chk("wr_data", 32'(mwdata[0]), 32'h1234);
        cyc();
        chk("wr_hold", 32'(mwv), 32'(2'b01));
        mwr[0] = 1'b1;
        cyc();
        mwr[0] = 1'b0;
        chk("wr_mwv_low", 32'(mwv), 32'(0));
        chk("wr_cwr", 32'(cwr), 32'(4'b0001));
        cyc();
        chk("wr_cwr_held", 32'(cwr), 32'(4'b0001));
        cwv[0] = 1'b0;
        cyc();
        chk("wr_cwr_drop", 32'(cwr), 32'(0));

        // Read and write together on consumer 1: read first, write regranted later.
        do_reset();
        crv[1] = 1'b1; craddr[1] = 8'h50;
        cwv[1] = 1'b1; cwaddr[1] = 8'h51; cwdata[1] = 16'hABCD;
        cyc();
        chk("rw_mrv", 32'(mrv), 32'(2'b01));
        chk("rw_mwv", 32'(mwv), 32'(0));
        chk("rw_raddr", 32'(mraddr[0]), 32'h50);
        mrr[0] = 1'b1; mrdata[0] = 16'h7777;
        cyc();
        mrr[0] = 1'b0;
        chk("rw_crr", 32'(crr), 32'(4'b0010));
        chk("rw_rdata", 32'(crdata[1]), 32'h7777);
        crv[1] = 1'b0;
        cyc();
        chk("rw_crr_drop", 32'(crr), 32'(0));
        chk("rw_no_early_wr", 32'(mwv), 32'(0));
        cyc();
        chk("rw_wr_grant", 32'(mwv), 32'(2'b01));
        chk("rw_waddr", 32'(mwaddr[0]), 32'h51);
        chk("rw_wdata", 32'(mwdata[0]), 32'hABCD);
        mwr[0] = 1'b1;
        cyc();
        mwr[0] = 1'b0;
        chk("rw_cwr", 32'(cwr), 32'(4'b0010));
        cwv[1] = 1'b0;
        cyc();
        chk("rw_cwr_drop", 32'(cwr), 32'(0));

        // Reset during READ_WAITING aborts; the request is then served normally.
        do_reset();
        crv[0] = 1'b1; craddr[0] = 8'h22;
        cyc();
        chk("rstmid_mrv", 32'(mrv), 32'(2'b01));
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rstmid_mrv0", 32'(mrv), 32'(0));
        chk("rstmid_addr0", 32'(mraddr[0]), 32'(0));
        chk("rstmid_crr0", 32'(crr), 32'(0));
        cyc();
        chk("rstmid_regrant", 32'(mrv), 32'(2'b01));
        chk("rstmid_addr", 32'(mraddr[0]), 32'h22);
        mrr[0] = 1'b1; mrdata[0] = 16'h5A5A;
        cyc();
        mrr[0] = 1'b0;
        chk("rstmid_crr", 32'(crr), 32'(4'b0001));
        chk("rstmid_data", 32'(crdata[0]), 32'h5A5A);
        crv[0] = 1'b0;
        cyc();
        chk("rstmid_drop", 32'(crr), 32'(0));

        // Randomized traffic against the reference model.
        for (int i = 0; i < 256; i++) begin
            tbmem[i]  = DW'($urandom);
            shadow[i] = tbmem[i];
        end
        do_reset();
        for (int u = 0; u < NC; u++) begin
            ph[u]     = 0;
            mk_rd[u]  = 1'b0;
            m_addr[u] = '0;
            m_wd[u]   = '0;
            m_rd[u]   = '0;
        end
        for (int ch = 0; ch < NCH; ch++) chan_u[ch] = -1;
        rr    = 0;
        p_crr = '0;
        p_cwr = '0;
        for (int cyc_n = 0; cyc_n < 3000; cyc_n++) begin
            compare_outputs();
            mem_respond();
            drive_consumers();
            model_step();
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
